// File: rtl/delay_line_nb.sv
// Retunable clocked delay line: circular buffer with a derived read pointer.
// Blanks repeated samples on delay increases and flags dropped ones on decreases.
module delay_line_nb #(
  parameter int WIDTH     = 8,
  parameter int MAX_DELAY = 16,
  parameter int SEL_W     = $clog2(MAX_DELAY + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  input  logic [SEL_W-1:0] delay_sel,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic             primed,
  output logic             skip
);

  localparam int PW = $clog2(MAX_DELAY);
  localparam logic [SEL_W-1:0] MAXD = SEL_W'(MAX_DELAY);
  localparam logic [SEL_W-1:0] ONE  = SEL_W'(1);
  localparam logic [PW-1:0]    LAST = PW'(MAX_DELAY - 1);
  localparam logic [PW-1:0]    DEP  = PW'(MAX_DELAY);

  logic [WIDTH:0]   mem [MAX_DELAY];
  logic [PW-1:0]    wp;
  logic [PW-1:0]    rp;
  logic [PW-1:0]    back;
  logic [SEL_W-1:0] h;
  logic [SEL_W-1:0] h_nxt;
  logic [SEL_W-1:0] b;
  logic [SEL_W-1:0] b_nxt;
  logic [SEL_W-1:0] dp;
  logic [SEL_W-1:0] dk;
  logic [WIDTH:0]   word;
  logic             inc;
  logic             primed_nxt;
  logic             skip_nxt;

  always_comb begin
    dk = delay_sel;
    if (delay_sel == '0)
      dk = ONE;
    else if (delay_sel > MAXD)
      dk = MAXD;
  end

  // D=1 reads the word being written this edge, so bypass the buffer
  always_comb begin
    back = PW'(dk - ONE);
    if (wp >= back)
      rp = wp - back;
    else
      rp = wp + DEP - back;
    word = (dk == ONE) ? {valid_in, data_in} : mem[rp];
  end

  always_comb begin
    h_nxt      = (h == MAXD) ? h : h + ONE;
    primed_nxt = (h_nxt >= dk);
  end

  // h==0 marks the first edge after reset: no delay change is evaluated
  always_comb begin
    b_nxt    = b;
    skip_nxt = 1'b0;
    inc      = 1'b0;
    if (h != '0) begin
      if (dk > dp) begin
        b_nxt = b + (dk - dp);
        inc   = 1'b1;
      end else if (dk < dp) begin
        if (b >= (dp - dk)) begin
          b_nxt = b - (dp - dk);
        end else begin
          b_nxt    = '0;
          skip_nxt = 1'b1;
        end
      end
    end
    if (!inc && (b_nxt != '0))
      b_nxt = b_nxt - ONE;
  end

  always_ff @(posedge clk) begin
    mem[wp] <= {valid_in, data_in};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp        <= '0;
      h         <= '0;
      b         <= '0;
      dp        <= ONE;
      data_out  <= '0;
      valid_out <= 1'b0;
      primed    <= 1'b0;
      skip      <= 1'b0;
    end else begin
      wp        <= (wp == LAST) ? '0 : wp + 1'b1;
      h         <= h_nxt;
      b         <= b_nxt;
      dp        <= dk;
      data_out  <= word[WIDTH-1:0];
      valid_out <= word[WIDTH] & primed_nxt & (b_nxt == '0);
      primed    <= primed_nxt;
      skip      <= skip_nxt;
    end
  end

endmodule

// File: tb/tb_delay_line_nb.sv
// Bench for delay_line_nb: table vectors, directed corner sequences,
// and randomized traffic against a history-array reference model.
module tb_delay_line_nb;

  localparam int W  = 8;
  localparam int M  = 16;
  localparam int SW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  data_in;
  logic          valid_in;
  logic [SW-1:0] delay_sel;
  logic [W-1:0]  data_out;
  logic          valid_out;
  logic          primed;
  logic          skip;

  delay_line_nb #(.WIDTH(W), .MAX_DELAY(M)) dut (
    .clk(clk),
    .rst(rst),
    .data_in(data_in),
    .valid_in(valid_in),
    .delay_sel(delay_sel),
    .data_out(data_out),
    .valid_out(valid_out),
    .primed(primed),
    .skip(skip)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // reference model state: full input history by edge number
  logic [W-1:0] hx [4096];
  logic         hv [4096];
  int           k, mb, mdp;
  logic [W-1:0] e_data;
  logic         e_valid, e_primed, e_skip;

  typedef struct {
    logic [SW-1:0] sel;
    logic [W-1:0]  x;
    logic          v;
    logic [W-1:0]  d;
    logic          ev;
    logic          ep;
    logic          es;
  } vec_t;
  vec_t tbl [8];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0h expected %0h",
               name, k, act, exp);
    end
  endtask

  task automatic model_reset();
    k   = 0;
    mb  = 0;
    mdp = 1;
  endtask

  task automatic model_edge();
    int d, idx;
    bit inc;
    d = (delay_sel == 0) ? 1 : ((int'(delay_sel) > M) ? M : int'(delay_sel));
    k++;
    hx[k % 4096] = data_in;
    hv[k % 4096] = valid_in;
    e_skip = 1'b0;
    inc = 1'b0;
    if (k > 1) begin
      if (d > mdp) begin
        mb += d - mdp;
        inc = 1'b1;
      end else if (d < mdp) begin
        if (mb >= mdp - d) mb -= mdp - d;
        else begin
          mb = 0;
          e_skip = 1'b1;
        end
      end
    end
    if (!inc && mb > 0) mb--;
    mdp = d;
    e_primed = (k >= d);
    idx = k + 1 - d;
    e_data = (idx >= 1) ? hx[idx % 4096] : '0;
    e_valid = e_primed && (idx >= 1) && hv[idx % 4096] && (mb == 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_edge();
    check("valid", 32'(valid_out), 32'(e_valid));
    check("primed", 32'(primed), 32'(e_primed));
    check("skip", 32'(skip), 32'(e_skip));
    if (e_primed) check("data", 32'(data_out), 32'(e_data));
  endtask

  // called just after an edge; asserts reset between edges
  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_data", 32'(data_out), 32'(0));
    check("rst_valid", 32'(valid_out), 32'(0));
    check("rst_primed", 32'(primed), 32'(0));
    check("rst_skip", 32'(skip), 32'(0));
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drive(input int sel, input int x, input bit v);
    delay_sel = SW'(sel);
    data_in   = W'(x);
    valid_in  = v;
  endtask

  initial begin
    int pat [5];
    rst = 1'b1;
    drive(4, 0, 1'b0);
    model_reset();
    #1;
    check("init_valid", 32'(valid_out), 32'(0));
    check("init_primed", 32'(primed), 32'(0));
    @(negedge clk);
    rst = 1'b0;

    // priming table at D=4
    for (int i = 0; i < 8; i++) begin
      tbl[i].sel = SW'(4);
      tbl[i].x   = W'(i + 1);
      tbl[i].v   = 1'b1;
      tbl[i].ev  = (i >= 3);
      tbl[i].ep  = (i >= 3);
      tbl[i].es  = 1'b0;
      tbl[i].d   = (i >= 3) ? W'(i - 2) : '0;
    end
    for (int i = 0; i < 8; i++) begin
      drive(int'(tbl[i].sel), int'(tbl[i].x), tbl[i].v);
      tick();
      check("tbl_valid", 32'(valid_out), 32'(tbl[i].ev));
      check("tbl_primed", 32'(primed), 32'(tbl[i].ep));
      check("tbl_skip", 32'(skip), 32'(tbl[i].es));
      if (tbl[i].ev) check("tbl_data", 32'(data_out), 32'(tbl[i].d));
    end

    // clamp low: delay_sel=0 behaves as D=1
    do_reset();
    for (int e = 1; e <= 5; e++) begin
      drive(0, e + 8'h40, 1'b1);
      tick();
      check("clamp0_valid", 32'(valid_out), 32'(1));
      check("clamp0_data", 32'(data_out), 32'(e + 8'h40));
    end

    // clamp high: delay_sel=20 behaves as D=16
    do_reset();
    for (int e = 1; e <= 18; e++) begin
      drive(20, e, 1'b1);
      tick();
      check("clamp20_valid", 32'(valid_out), 32'(e >= 16));
      if (e >= 16) check("clamp20_data", 32'(data_out), 32'(e - 15));
    end

    // increase 4 -> 7 where output would be 0x10
    do_reset();
    for (int e = 1; e <= 25; e++) begin
      drive((e < 19) ? 4 : 7, e, 1'b1);
      tick();
      if (e >= 19 && e <= 21) check("inc_blank", 32'(valid_out), 32'(0));
      if (e >= 22) begin
        check("inc_valid", 32'(valid_out), 32'(1));
        check("inc_data", 32'(data_out), 32'(e - 6));
      end
    end

    // decrease 8 -> 5 after output 0x20
    do_reset();
    for (int e = 1; e <= 44; e++) begin
      drive((e < 40) ? 8 : 5, e, 1'b1);
      tick();
      if (e == 39) check("dec_pre", 32'(data_out), 32'(8'h20));
      if (e >= 40) begin
        check("dec_skip", 32'(skip), 32'(e == 40));
        check("dec_valid", 32'(valid_out), 32'(1));
        check("dec_data", 32'(data_out), 32'(e - 4));
      end
    end

    // blank absorption: 4 -> 8 -> 6 on consecutive edges leaves B=1
    do_reset();
    for (int e = 1; e <= 24; e++) begin
      drive((e < 21) ? 4 : ((e == 21) ? 8 : 6), e, 1'b1);
      tick();
      if (e == 22) begin
        check("abs_blank", 32'(valid_out), 32'(0));
        check("abs_skip", 32'(skip), 32'(0));
      end
      if (e == 23) begin
        check("abs_valid", 32'(valid_out), 32'(1));
        check("abs_data", 32'(data_out), 32'(8'h12));
      end
    end

    // valid gaps at D=3
    do_reset();
    pat = '{1, 0, 1, 1, 0};
    for (int e = 1; e <= 9; e++) begin
      drive(3, e, (e <= 5) ? bit'(pat[e-1]) : 1'b0);
      tick();
      if (e >= 3 && e <= 7)
        check("gap_valid", 32'(valid_out), 32'(pat[e-3]));
    end

    // reset mid-stream while valid_out=1
    for (int e = 1; e <= 4; e++) begin
      drive(3, e + 8'h60, 1'b1);
      tick();
    end
    check("mid_pre", 32'(valid_out), 32'(1));
    do_reset();
    for (int e = 1; e <= 6; e++) begin
      drive(4, e + 8'h80, 1'b1);
      tick();
      check("mid_valid", 32'(valid_out), 32'(e >= 4));
      if (e >= 4) check("mid_data", 32'(data_out), 32'(e - 3 + 8'h80));
    end

    // randomized traffic against the model
    do_reset();
    delay_sel = SW'($urandom_range(0, 20));
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) delay_sel = SW'($urandom_range(0, 20));
      data_in  = W'($urandom);
      valid_in = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 299) == 0) do_reset();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/delay_line_nb.md
Name: delay_line_nb

Overview:
- Parametrised, clocked successor to the 1-bit inverter-chain delay in async_lib.
- Delays a WIDTH-bit data word plus its valid flag by a run-time-selectable number of clock cycles, from 1 to MAX_DELAY.
- Built as a circular buffer with a write pointer and a derived read pointer.
- Handles delay changes cleanly: samples repeated by a delay increase are blanked, and samples skipped by a delay decrease are flagged.
- Used wherever a matched, retunable latency is needed to align data paths.

Parameters:
- WIDTH, 8, data word width in bits.
- MAX_DELAY, 16, maximum delay in cycles and buffer depth; must be at least 2.
- SEL_W, $clog2(MAX_DELAY+1), width of delay_sel.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- data_in  input  WIDTH  input word, sampled every edge.
- valid_in  input  1  qualifier for data_in, sampled every edge.
- delay_sel  input  SEL_W  requested delay D in cycles, sampled every edge.
- data_out  output  WIDTH  delayed word, registered.
- valid_out  output  1  delayed qualifier, masked as defined below, registered.
- primed  output  1  history is sufficient for the current D, registered.
- skip  output  1  one-cycle pulse: samples were dropped by a delay decrease, registered.

Behaviour:
- Reset (async, immediate):
  - data_out=0, valid_out=0, primed=0, skip=0.
  - Write pointer=0, history count H=0, blank counter B=0, previous delay Dp=1.
  - Buffer contents are not reset; H masks them.
- Effective delay at edge k: Dk = clamp(delay_sel, 1, MAX_DELAY). A delay_sel of 0 acts as 1; values above MAX_DELAY act as MAX_DELAY.
- Indexing: x[k] and v[k] are data_in and valid_in sampled at edge k. After edge k:
  - data_out = x[k+1-Dk].
  - Dk=1 is therefore a plain register with one cycle of latency.
- Buffer:
  - Every edge writes {valid_in, data_in} at the write pointer, which then increments and wraps MAX_DELAY-1 -> 0.
  - No stall or backpressure; the line advances every cycle.
- History count H:
  - Counts edges since reset release, including the current edge.
  - Saturates at MAX_DELAY.
  - primed after edge k = (H >= Dk).
- valid_out after edge k = v[k+1-Dk] AND primed AND (B==0 after the update at edge k).
- data_out is updated even when valid_out=0. Downstream ignores it.
- Delay change, evaluated at every edge except the first after reset. On that first edge Dp is simply loaded with Dk.
  - Increase, Δ = Dk - Dp > 0:
    - Read position moves back Δ samples, which were already emitted.
    - B += Δ, including the current edge.
    - valid_out is forced 0 while B>0, so no sample is emitted twice.
  - Decrease, Δ = Dp - Dk > 0:
    - If B >= Δ: B -= Δ, and skip stays 0 (the dropped samples were already being blanked).
    - Otherwise: B = 0 and skip=1 for exactly this one cycle, since Δ-B_old samples are lost.
  - Equal: no action.
- Each edge without an increase: B decrements by 1 if nonzero, after the decrease rule is applied. B never exceeds MAX_DELAY-1.
- Dp <= Dk every edge.
- Simultaneous events:
  - A delay change coincident with valid_in=0 follows the same rules, since blanking is positional.
  - A delay change while primed=0 still updates B; primed masking applies on top.
- Reset mid-stream: all outputs drop on assertion. After release the line re-primes from H=0, and no pre-reset data appears with valid_out=1.

Test Plan:
- Priming: WIDTH=8, MAX_DELAY=16, delay_sel=4, ramp data_in=0x01,0x02,... with valid_in=1 from the first edge after reset.
  -> valid_out=0 and primed=0 after edges 1-3.
  -> After edge 4: valid_out=1, data_out=0x01, primed=1. Consecutive ramp values follow on every cycle after that.
- Clamping: delay_sel=0 -> output equals previous-edge input (D=1). delay_sel=20 -> first valid output after edge 16, equal to 0x01.
- Increase: steady D=4 on the ramp, switch delay_sel to 7 at the edge where the output would be 0x10.
  -> valid_out=0 for 3 cycles.
  -> Next valid data_out=0x10. No value is emitted twice.
- Decrease: steady D=8, output at 0x20, switch to 5.
  -> skip=1 for one cycle.
  -> Next outputs are 0x24, 0x25, ...; 0x21-0x23 never appear and valid_out stays 1.
- Valid gaps and blank absorption:
  - valid_in pattern 1,0,1,1,0 at D=3 -> valid_out pattern identical, shifted 3 cycles.
  - With D 4 -> 8 then 8 -> 6 on consecutive edges -> B ends at 1, skip stays 0.
- Reset mid-stream: assert rst asynchronously between edges while valid_out=1.
  -> All outputs 0 immediately.
  -> After release with D=4, first valid_out occurs at edge 4 with post-reset data only.
